// File: rtl/iter_div_unit.sv
// Iterative integer divider for the execute stage.
// Restoring division on operand magnitudes, retiring RADIX_LOG2 quotient bits
// per CALC cycle, followed by a one-cycle sign fix-up. Results are held under
// a valid/ack handshake; flush_i abandons any operation in flight.
// Normal latency: valid_o is first high after the (N+2)-th rising edge,
// counting the accepting edge as edge one (N = DATA_W/RADIX_LOG2).
module iter_div_unit #(
   parameter int DATA_W     = 32,
   parameter int RADIX_LOG2 = 2
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst_n,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              flush_i,
   input  logic              ack_i,
   output logic              ready_o,
   output logic              busy_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o,
   output logic              div_by_zero_o
);

   localparam int N_ITER = DATA_W / RADIX_LOG2;
   localparam int CNT_W  = $clog2(N_ITER) + 1;
   localparam int RW     = DATA_W + 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CALC  = 2'd1;
   localparam logic [1:0] ST_FIXUP = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_ITER - 1);
   localparam logic [DATA_W-1:0] DW_ZERO  = {DATA_W{1'b0}};
   localparam logic [DATA_W-1:0] DW_ONES  = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] DW_ONE   = {{(DATA_W-1){1'b0}}, 1'b1};

   // Two's complement negation.
   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] val);
      return ~val + DW_ONE;
   endfunction

   // Magnitude of an operand: negated only for a signed, negative value.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] val,
                                                   input logic              is_signed);
      if (is_signed && val[DATA_W-1]) begin
         return negate(val);
      end else begin
         return val;
      end
   endfunction

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              signed_r;
   logic              dd_sign_r;
   logic              dv_sign_r;
   logic [DATA_W-1:0] rem_r;
   logic [DATA_W-1:0] quo_r;
   logic [DATA_W-1:0] dvs_r;
   logic              ready_r;
   logic              busy_r;
   logic              valid_r;
   logic              dbz_r;
   logic [DATA_W-1:0] quot_out_r;
   logic [DATA_W-1:0] rem_out_r;

   logic              accept_s;
   logic              divisor_zero_s;
   logic [RW-1:0]     shifted_s;
   logic [RW-1:0]     d1_s;
   logic [RW-1:0]     d2_s;
   logic [RW-1:0]     d3_s;
   logic [1:0]        qd_s;
   logic [DATA_W-1:0] rem_nxt_s;
   logic [DATA_W-1:0] quo_nxt_s;
   logic [DATA_W-1:0] quot_fix_s;
   logic [DATA_W-1:0] rem_fix_s;

   assign accept_s       = (state_r == ST_IDLE) && start_i && !flush_i;
   assign divisor_zero_s = (divisor_i == DW_ZERO);

   // Next-state selection; flush wins over everything else, including start.
   always_comb begin
      state_nxt_s = state_r;
      if (flush_i) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  state_nxt_s = divisor_zero_s ? ST_DONE : ST_CALC;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_CALC: begin
               if (cnt_r == CNT_LAST) begin
                  state_nxt_s = ST_FIXUP;
               end else begin
                  state_nxt_s = ST_CALC;
               end
            end
            ST_FIXUP: state_nxt_s = ST_DONE;
            ST_DONE: begin
               if (ack_i) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // One restoring iteration: shift the next dividend bits into the partial
   // remainder, then keep the largest multiple of the divisor that fits.
   always_comb begin
      shifted_s = RW'({rem_r, quo_r[DATA_W-1 -: RADIX_LOG2]});
      d1_s      = {2'b00, dvs_r};
      d2_s      = {1'b0, dvs_r, 1'b0};
      d3_s      = d1_s + d2_s;
      qd_s      = 2'b00;
      rem_nxt_s = DATA_W'(shifted_s);
      if (RADIX_LOG2 == 2) begin
         if (shifted_s >= d3_s) begin
            qd_s      = 2'b11;
            rem_nxt_s = DATA_W'(shifted_s - d3_s);
         end else if (shifted_s >= d2_s) begin
            qd_s      = 2'b10;
            rem_nxt_s = DATA_W'(shifted_s - d2_s);
         end else if (shifted_s >= d1_s) begin
            qd_s      = 2'b01;
            rem_nxt_s = DATA_W'(shifted_s - d1_s);
         end else begin
            qd_s      = 2'b00;
            rem_nxt_s = DATA_W'(shifted_s);
         end
      end else begin
         if (shifted_s >= d1_s) begin
            qd_s      = 2'b01;
            rem_nxt_s = DATA_W'(shifted_s - d1_s);
         end else begin
            qd_s      = 2'b00;
            rem_nxt_s = DATA_W'(shifted_s);
         end
      end
      quo_nxt_s = {quo_r[DATA_W-1-RADIX_LOG2:0], qd_s[RADIX_LOG2-1:0]};
   end

   // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
   always_comb begin
      quot_fix_s = quo_r;
      rem_fix_s  = rem_r;
      if (signed_r) begin
         quot_fix_s = (dd_sign_r ^ dv_sign_r) ? negate(quo_r) : quo_r;
         rem_fix_s  = dd_sign_r ? negate(rem_r) : rem_r;
      end else begin
         quot_fix_s = quo_r;
         rem_fix_s  = rem_r;
      end
   end

   // State register and the handshake flags decoded from the next state.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_r <= ST_IDLE;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s == ST_IDLE);
         busy_r  <= (state_nxt_s == ST_CALC) || (state_nxt_s == ST_FIXUP);
         valid_r <= (state_nxt_s == ST_DONE);
      end
   end

   // Operand latch on acceptance and the iteration datapath during CALC.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         cnt_r     <= {CNT_W{1'b0}};
         signed_r  <= 1'b0;
         dd_sign_r <= 1'b0;
         dv_sign_r <= 1'b0;
         rem_r     <= DW_ZERO;
         quo_r     <= DW_ZERO;
         dvs_r     <= DW_ZERO;
      end else if (accept_s) begin
         cnt_r     <= {CNT_W{1'b0}};
         signed_r  <= signed_i;
         dd_sign_r <= signed_i & dividend_i[DATA_W-1];
         dv_sign_r <= signed_i & divisor_i[DATA_W-1];
         rem_r     <= DW_ZERO;
         quo_r     <= magnitude(dividend_i, signed_i);
         dvs_r     <= magnitude(divisor_i, signed_i);
      end else if ((state_r == ST_CALC) && !flush_i) begin
         cnt_r <= cnt_r + CNT_ONE;
         rem_r <= rem_nxt_s;
         quo_r <= quo_nxt_s;
      end else begin
         cnt_r <= cnt_r;
         rem_r <= rem_r;
         quo_r <= quo_r;
      end
   end

   // Result registers: loaded on a zero-divisor acceptance or at FIXUP, then held.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         quot_out_r <= DW_ZERO;
         rem_out_r  <= DW_ZERO;
         dbz_r      <= 1'b0;
      end else if (flush_i) begin
         dbz_r <= 1'b0;
      end else if (accept_s) begin
         if (divisor_zero_s) begin
            quot_out_r <= DW_ONES;
            rem_out_r  <= dividend_i;
            dbz_r      <= 1'b1;
         end else begin
            dbz_r <= 1'b0;
         end
      end else if (state_r == ST_FIXUP) begin
         quot_out_r <= quot_fix_s;
         rem_out_r  <= rem_fix_s;
      end else begin
         dbz_r <= dbz_r;
      end
   end

   assign ready_o       = ready_r;
   assign busy_o        = busy_r;
   assign valid_o       = valid_r;
   assign quotient_o    = quot_out_r;
   assign remainder_o   = rem_out_r;
   assign div_by_zero_o = dbz_r;

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: a 32-bit radix-4 instance and a
// 16-bit radix-2 instance, checked against an arithmetic reference model.
module tb_iter_div_unit;

   logic cpu_clk_50M = 1'b0;
   logic cpu_rst_n;
   always #10 cpu_clk_50M = ~cpu_clk_50M;

   // 32-bit, radix-4 instance
   logic        a_start, a_signed, a_flush, a_ack;
   logic [31:0] a_dd, a_dv;
   logic        a_ready, a_busy, a_valid, a_dbz;
   logic [31:0] a_quot, a_rem;

   // 16-bit, radix-2 instance
   logic        b_start, b_signed, b_flush, b_ack;
   logic [15:0] b_dd, b_dv;
   logic        b_ready, b_busy, b_valid, b_dbz;
   logic [15:0] b_quot, b_rem;

   int n_checks = 0;
   int n_fail   = 0;

   iter_div_unit #(.DATA_W(32), .RADIX_LOG2(2)) dut32 (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
      .start_i(a_start), .signed_i(a_signed), .dividend_i(a_dd), .divisor_i(a_dv),
      .flush_i(a_flush), .ack_i(a_ack), .ready_o(a_ready), .busy_o(a_busy),
      .valid_o(a_valid), .quotient_o(a_quot), .remainder_o(a_rem),
      .div_by_zero_o(a_dbz));

   iter_div_unit #(.DATA_W(16), .RADIX_LOG2(1)) dut16 (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
      .start_i(b_start), .signed_i(b_signed), .dividend_i(b_dd), .divisor_i(b_dv),
      .flush_i(b_flush), .ack_i(b_ack), .ready_o(b_ready), .busy_o(b_busy),
      .valid_o(b_valid), .quotient_o(b_quot), .remainder_o(b_rem),
      .div_by_zero_o(b_dbz));

   // Reference: truncating division on w-bit values, with the zero-divisor rule.
   function automatic void ref_div(input int w, input bit sgn,
                                   input longint unsigned dd, input longint unsigned dv,
                                   output longint unsigned q, output longint unsigned r);
      longint unsigned mask;
      longint a, b;
      mask = (64'd1 << w) - 64'd1;
      if (dv == 64'd0) begin
         q = mask;
         r = dd & mask;
      end else if (sgn) begin
         a = ((dd >> (w - 1)) & 64'd1) != 64'd0 ? longint'(dd) - longint'(64'd1 << w) : longint'(dd);
         b = ((dv >> (w - 1)) & 64'd1) != 64'd0 ? longint'(dv) - longint'(64'd1 << w) : longint'(dv);
         q = $unsigned(a / b) & mask;
         r = $unsigned(a % b) & mask;
      end else begin
         q = (dd / dv) & mask;
         r = (dd % dv) & mask;
      end
   endfunction

   // Run one 32-bit division and check latency, result, hold and ack.
   task automatic do32(input bit sgn, input logic [31:0] dd, input logic [31:0] dv, input string tag);
      longint unsigned eq, er;
      logic [31:0] eq32, er32;
      int edges, exp_lat;
      ref_div(32, sgn, {32'd0, dd}, {32'd0, dv}, eq, er);
      eq32 = eq[31:0];
      er32 = er[31:0];
      exp_lat = (dv == 32'd0) ? 1 : 18;
      @(negedge cpu_clk_50M);
      n_checks++;
      if (a_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_before_start: got %b expected 1", tag, a_ready); end
      a_start = 1'b1; a_signed = sgn; a_dd = dd; a_dv = dv;
      @(negedge cpu_clk_50M);
      a_start = 1'b0; a_dd = $urandom; a_dv = $urandom; a_signed = 1'($urandom);
      edges = 1;
      if (dv != 32'd0) begin
         n_checks++;
         if (a_busy !== 1'b1 || a_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s busy_after_accept: got busy=%b ready=%b expected 1/0", tag, a_busy, a_ready);
         end
      end
      while (a_valid !== 1'b1 && edges < 64) begin
         @(negedge cpu_clk_50M);
         edges++;
      end
      n_checks++;
      if (edges != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, edges, exp_lat); end
      n_checks++;
      if (a_quot !== eq32 || a_rem !== er32 || a_dbz !== (dv == 32'd0)) begin
         n_fail++;
         $display("FAIL %s result: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                  tag, a_quot, a_rem, a_dbz, eq32, er32, (dv == 32'd0));
      end
      repeat (2) @(negedge cpu_clk_50M);
      n_checks++;
      if (a_valid !== 1'b1 || a_quot !== eq32 || a_rem !== er32) begin
         n_fail++; $display("FAIL %s hold: got valid=%b q=%h r=%h expected 1 %h %h", tag, a_valid, a_quot, a_rem, eq32, er32);
      end
      a_ack = 1'b1;
      @(negedge cpu_clk_50M);
      a_ack = 1'b0;
      n_checks++;
      if (a_ready !== 1'b1 || a_valid !== 1'b0 || a_quot !== eq32) begin
         n_fail++; $display("FAIL %s after_ack: got ready=%b valid=%b q=%h expected 1 0 %h", tag, a_ready, a_valid, a_quot, eq32);
      end
   endtask

   // Run one 16-bit division; hold_start keeps start_i high while the unit is busy.
   task automatic do16(input bit sgn, input logic [15:0] dd, input logic [15:0] dv,
                       input bit hold_start, input string tag);
      longint unsigned eq, er;
      logic [15:0] eq16, er16;
      int edges, exp_lat, rises;
      ref_div(16, sgn, {48'd0, dd}, {48'd0, dv}, eq, er);
      eq16 = eq[15:0];
      er16 = er[15:0];
      exp_lat = (dv == 16'd0) ? 1 : 18;
      @(negedge cpu_clk_50M);
      b_start = 1'b1; b_signed = sgn; b_dd = dd; b_dv = dv;
      @(negedge cpu_clk_50M);
      b_start = hold_start; b_dd = 16'($urandom); b_dv = 16'($urandom | 1);
      edges = 1;
      while (b_valid !== 1'b1 && edges < 64) begin
         @(negedge cpu_clk_50M);
         edges++;
      end
      b_start = 1'b0;
      n_checks++;
      if (edges != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, edges, exp_lat); end
      n_checks++;
      if (b_quot !== eq16 || b_rem !== er16 || b_dbz !== (dv == 16'd0)) begin
         n_fail++;
         $display("FAIL %s result: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                  tag, b_quot, b_rem, b_dbz, eq16, er16, (dv == 16'd0));
      end
      b_ack = 1'b1;
      @(negedge cpu_clk_50M);
      b_ack = 1'b0;
      n_checks++;
      if (b_ready !== 1'b1 || b_valid !== 1'b0) begin
         n_fail++; $display("FAIL %s after_ack: got ready=%b valid=%b expected 1 0", tag, b_ready, b_valid);
      end
      if (hold_start) begin
         rises = 0;
         repeat (25) begin
            @(negedge cpu_clk_50M);
            if (b_valid === 1'b1 || b_busy === 1'b1) rises++;
         end
         n_checks++;
         if (rises != 0) begin n_fail++; $display("FAIL %s extra_result: got %0d active cycles expected 0", tag, rises); end
      end
   endtask

   task automatic test_reset();
      cpu_rst_n = 1'b0;
      a_start = 1'b0; a_signed = 1'b0; a_flush = 1'b0; a_ack = 1'b0; a_dd = 32'd0; a_dv = 32'd0;
      b_start = 1'b0; b_signed = 1'b0; b_flush = 1'b0; b_ack = 1'b0; b_dd = 16'd0; b_dv = 16'd0;
      repeat (3) @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;
      repeat (2) @(negedge cpu_clk_50M);
      n_checks++;
      if ({a_ready, a_busy, a_valid, a_dbz} !== 4'b1000 || a_quot !== 32'd0 || a_rem !== 32'd0) begin
         n_fail++; $display("FAIL reset32: got rdy/bsy/vld/dbz=%b q=%h r=%h expected 1000 0 0",
                            {a_ready, a_busy, a_valid, a_dbz}, a_quot, a_rem);
      end
      n_checks++;
      if ({b_ready, b_busy, b_valid, b_dbz} !== 4'b1000 || b_quot !== 16'd0 || b_rem !== 16'd0) begin
         n_fail++; $display("FAIL reset16: got rdy/bsy/vld/dbz=%b q=%h r=%h expected 1000 0 0",
                            {b_ready, b_busy, b_valid, b_dbz}, b_quot, b_rem);
      end
   endtask

   task automatic test_directed();
      do32(1'b0, 32'd100, 32'd7, "u_100_7");
      do32(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, "s_m7_2");
      do32(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, "s_7_m2");
      do32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_min_m1");
      do32(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "u_max_1");
      do32(1'b0, 32'h0000_0003, 32'hFFFF_FFFF, "u_small_big");
   endtask

   task automatic test_div_by_zero();
      do32(1'b0, 32'd5, 32'd0, "dbz_5_0");
      do32(1'b1, 32'hFFFF_FFFB, 32'd0, "dbz_s_m5_0");
   endtask

   task automatic test_flush();
      int seen;
      @(negedge cpu_clk_50M);
      a_start = 1'b1; a_signed = 1'b0; a_dd = 32'd100; a_dv = 32'd7;
      @(negedge cpu_clk_50M);
      a_start = 1'b0;
      repeat (4) @(negedge cpu_clk_50M);
      a_flush = 1'b1;
      @(negedge cpu_clk_50M);
      a_flush = 1'b0;
      n_checks++;
      if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_calc: got ready=%b busy=%b valid=%b expected 1 0 0", a_ready, a_busy, a_valid);
      end
      seen = 0;
      repeat (25) begin
         @(negedge cpu_clk_50M);
         if (a_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); end
      do32(1'b0, 32'd100, 32'd7, "reissue_100_7");
      // flush while a zero-divisor result is being held
      @(negedge cpu_clk_50M);
      a_start = 1'b1; a_dd = 32'd9; a_dv = 32'd0;
      @(negedge cpu_clk_50M);
      a_start = 1'b0; a_flush = 1'b1;
      @(negedge cpu_clk_50M);
      a_flush = 1'b0;
      n_checks++;
      if (a_valid !== 1'b0 || a_dbz !== 1'b0 || a_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_done: got valid=%b dbz=%b ready=%b expected 0 0 1", a_valid, a_dbz, a_ready);
      end
      // flush together with start in IDLE: start must be dropped
      a_start = 1'b1; a_flush = 1'b1; a_dd = 32'd50; a_dv = 32'd5;
      @(negedge cpu_clk_50M);
      a_start = 1'b0; a_flush = 1'b0;
      n_checks++;
      if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_vs_start: got ready=%b busy=%b valid=%b expected 1 0 0", a_ready, a_busy, a_valid);
      end
   endtask

   task automatic test_async_reset();
      do32(1'b0, 32'd100, 32'd7, "pre_reset");
      @(negedge cpu_clk_50M);
      a_start = 1'b1; a_dd = 32'd1000; a_dv = 32'd3;
      @(negedge cpu_clk_50M);
      a_start = 1'b0;
      repeat (3) @(negedge cpu_clk_50M);
      #3 cpu_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({a_ready, a_busy, a_valid, a_dbz} !== 4'b1000 || a_quot !== 32'd0 || a_rem !== 32'd0) begin
         n_fail++; $display("FAIL async_reset: got rdy/bsy/vld/dbz=%b q=%h r=%h expected 1000 0 0",
                            {a_ready, a_busy, a_valid, a_dbz}, a_quot, a_rem);
      end
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;
      do32(1'b0, 32'd100, 32'd7, "post_reset");
   endtask

   task automatic test_width16();
      do16(1'b0, 16'hFFFF, 16'h0003, 1'b0, "w16_ffff_3");
      do16(1'b1, 16'h8000, 16'hFFFF, 1'b0, "w16_min_m1");
      do16(1'b0, 16'h1234, 16'h0000, 1'b0, "w16_dbz");
      do16(1'b0, 16'd1000, 16'd33, 1'b1, "w16_start_held");
      for (int i = 0; i < 40; i++) begin
         do16(1'($urandom), 16'($urandom), 16'($urandom_range(0, 7) == 0 ? 0 : $urandom), 1'b0, "w16_rand");
      end
   endtask

   task automatic test_random();
      logic [31:0] dd, dv;
      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 7))
            0:       dv = 32'd0;
            1:       dv = 32'hFFFF_FFFF;
            2:       dv = 32'($urandom_range(1, 15));
            3:       dv = 32'h8000_0000;
            default: dv = $urandom;
         endcase
         dd = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
         do32(1'($urandom), dd, dv, "rand32");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_by_zero();
      test_flush();
      test_async_reset();
      test_width16();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
